down_counter: RTL
=================

DOWN_COUNTER -- requirements
Module: down_counter

Interface
REQ-001 Parameter WIDTH, default 8, width of count and load value.
REQ-002 Parameter PRESCALE, default 1, number of enabled cycles per decrement (legal range 1..256).
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low; 0 = reset.
REQ-005 load  input  1  load request, sampled on rising clk.
REQ-006 load_val  input  WIDTH  start/reload value, sampled when load=1.
REQ-007 en  input  1  count enable; 0 = hold.
REQ-008 auto_reload  input  1  1 = restart from stored value on expiry.
REQ-009 count  output  WIDTH  current registered count.
REQ-010 busy  output  1  1 while state is RUN or HOLD.
REQ-011 done  output  1  one-cycle expiry pulse, registered.

Function
REQ-012 FSM states SHALL be IDLE, RUN, HOLD; reset state IDLE.
REQ-013 load=1 at edge k SHALL set count=load_val, reload_reg=load_val, and clear the prescaler after edge k, in any state.
REQ-014 load with load_val!=0 SHALL enter RUN if en=1, else HOLD; load with load_val==0 SHALL enter IDLE with no done pulse.
REQ-015 load SHALL have priority over decrement and expiry in the same cycle.
REQ-016 RUN with en=1 SHALL advance the prescaler; a decrement occurs on the PRESCALE-th enabled cycle after load (PRESCALE=1: every enabled cycle).
REQ-017 First decrement SHALL occur no earlier than edge k+1 after a load at edge k.
REQ-018 RUN with en=0 SHALL go to HOLD; HOLD with en=1 SHALL return to RUN; count and prescaler are frozen in HOLD.
REQ-019 Decrement from count==1 SHALL expire: done=1 for exactly the following cycle.
REQ-020 On expiry with auto_reload=0: count=0, state IDLE.
REQ-021 On expiry with auto_reload=1: count=reload_reg (0 never shown), state stays RUN.
REQ-022 In IDLE, en SHALL have no effect and count SHALL hold its value.
REQ-023 count SHALL never wrap below 0 (no 0 -> all-ones transition).
REQ-024 Arithmetic SHALL be unsigned WIDTH-bit; prescaler width = clog2(PRESCALE)+1.

Reset
REQ-025 rst=0 SHALL asynchronously force count=0, busy=0, done=0, reload_reg=0, prescaler=0, state IDLE.
REQ-026 Reset asserted mid-count SHALL abort without a done pulse.
REQ-027 First active edge after rst rises SHALL behave as IDLE with inputs sampled normally.

Structure
REQ-028 Shared package SHALL hold the state encoding (IDLE=2'b00, RUN=2'b01, HOLD=2'b10) and default WIDTH.
REQ-029 Prescaler SHALL be one sub-module, tick_gen (inputs clk, rst, clr, en; output tick).
REQ-030 All outputs SHALL be driven directly from registers.

Verification
REQ-031 Reset low at t=0, release after 10 ns -> count=0, busy=0, done=0 throughout reset.
REQ-032 load_val=5, en=1, auto_reload=0, PRESCALE=1 -> count 5,4,3,2,1,0 on successive edges; done high one cycle with count=0; busy falls with it.
REQ-033 load_val=3, en=1, 2 cycles later en=0 for 4 cycles -> count holds at 1, busy=1; en=1 again -> count 0, done pulse.
REQ-034 load_val=2, auto_reload=1 -> count 2,1,2,1,...; done pulses each time 1->2; load_val=0 mid-run -> IDLE, count=0, no done.
REQ-035 load_val=4 running, load_val=9 asserted while count==1 -> count=9, no done that cycle.
REQ-036 rst=0 while count==3 -> count=0, state IDLE, done never asserted; PRESCALE=4 run -> one decrement per 4 enabled cycles.

Source files
------------

// File: rtl/down_counter_pkg.sv
// rtl/down_counter_pkg.sv - shared constants and helpers for the down counter
//
// Purpose : state encoding, default data width and the prescaler width
//           helper shared by down_counter and tick_gen.
// Ports   : none (package).

package down_counter_pkg;

    // Default width of count, load value and reload register.
    localparam int DEFAULT_WIDTH = 8;

    // Controller state encoding. The 2'b11 code is unused and recovers to IDLE.
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_HOLD = 2'b10;

    // Width of the prescaler phase counter: large enough to hold PRESCALE-1,
    // and never narrower than one bit (PRESCALE=1 gives $clog2 = 0).
    function automatic int prescale_width(input int prescale);
        return $clog2(prescale) + 1;
    endfunction

endpackage

// File: rtl/down_counter_tick_gen.sv
// rtl/down_counter_tick_gen.sv - enabled-cycle prescaler producing decrement ticks
//
// Purpose : counts enabled cycles and raises tick on every PRESCALE-th one.
//           The phase counter restarts from zero on clr and after each tick.
// Ports   : clk  - system clock, rising edge
//           rst  - asynchronous reset, active low
//           clr  - synchronous clear of the phase counter (dominates en)
//           en   - advance the phase counter this cycle
//           tick - combinational: this enabled cycle completes a prescale period

module tick_gen
    import down_counter_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int              PW   = prescale_width(PRESCALE);
    localparam logic [PW-1:0]   LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] phase;

    // A tick is the PRESCALE-th enabled cycle since the last clear or tick.
    // clr suppresses it so that a load never coincides with a decrement.
    assign tick = en && !clr && (phase == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase <= '0;
        end else if (clr) begin
            phase <= '0;
        end else if (en) begin
            if (phase == LAST) begin
                phase <= '0;
            end else begin
                phase <= phase + PW'(1);
            end
        end
    end

endmodule

// File: rtl/down_counter.sv
// rtl/down_counter.sv - loadable prescaled down counter with hold and auto-reload
//
// Purpose : counts down from a loaded value, one step per PRESCALE enabled
//           cycles, pulses done for one cycle on expiry and either stops
//           at zero or restarts from the stored reload value.
// Ports   : clk         - system clock, rising edge
//           rst         - asynchronous reset, active low
//           load        - load request (priority over counting)
//           load_val    - start/reload value captured on load
//           en          - count enable; low pauses the count (HOLD)
//           auto_reload - restart from the reload value on expiry
//           count       - registered current count
//           busy        - registered, high while in RUN or HOLD
//           done        - registered one-cycle expiry pulse

module down_counter
    import down_counter_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    logic [1:0]       state;
    logic [1:0]       state_d;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] reload_q;
    logic [WIDTH-1:0] reload_d;
    logic             done_d;
    logic             tick_en;
    logic             tick;

    // The prescaler only advances while actually running; HOLD and IDLE
    // freeze it. load clears it so the first decrement lands PRESCALE
    // enabled cycles after the load edge.
    assign tick_en = (state == ST_RUN) && en;

    tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (load),
        .en   (tick_en),
        .tick (tick)
    );

    always_comb begin
        state_d  = state;
        count_d  = count;
        reload_d = reload_q;
        done_d   = 1'b0;

        if (load) begin
            count_d  = load_val;
            reload_d = load_val;
            // A zero load is an immediate stop, never an expiry.
            if (load_val == '0) begin
                state_d = ST_IDLE;
            end else if (en) begin
                state_d = ST_RUN;
            end else begin
                state_d = ST_HOLD;
            end
        end else begin
            case (state)
                ST_RUN: begin
                    if (!en) begin
                        state_d = ST_HOLD;
                    end else if (tick) begin
                        // Expiry is checked with <= so a stray zero count
                        // can never underflow to all-ones.
                        if (count <= WIDTH'(1)) begin
                            done_d = 1'b1;
                            if (auto_reload && (reload_q != '0)) begin
                                count_d = reload_q;
                            end else begin
                                count_d = '0;
                                state_d = ST_IDLE;
                            end
                        end else begin
                            count_d = count - WIDTH'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    // Resuming costs one edge; the count moves again only
                    // once back in RUN.
                    if (en) begin
                        state_d = ST_RUN;
                    end
                end
                ST_IDLE: begin
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            count    <= '0;
            reload_q <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_d;
            count    <= count_d;
            reload_q <= reload_d;
            // busy is registered from the next state so it tracks state
            // exactly while still coming straight off a flop.
            busy     <= (state_d != ST_IDLE);
            done     <= done_d;
        end
    end

endmodule
